pulse_rate_counter: RTL
=======================

Name: pulse_rate_counter

Overview:
Receive side of the simulated radioactive source. Takes the asynchronous single-cycle pulse stream from the random pulse generator, or any external detector line, and synchronises and edge-detects it. Applies a Geiger-style dead time after each accepted hit, counts hits over a fixed gate window, and hands each window's count downstream through a valid/ready register. Sits between the pulse source and the readout/display logic.

Parameters:
CNT_W, 16, width of the hit accumulator and result.
GATE_CYCLES, 1000, gate window length in clk cycles (>=2).
DEAD_CYCLES, 8, blanking cycles after each accepted hit (0 = no dead time).
SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
ena  in  1  counting enable.
pulse_in  in  1  raw pulse line, asynchronous to clk, active-high.
count_out  out  CNT_W  hit count of last completed window.
count_valid  out  1  count_out holds an unconsumed result.
count_ready  in  1  consumer accepts result.
count_sat  out  1  result window saturated at 2^CNT_W-1.
overrun  out  1  sticky: a result was overwritten unread.
dead_active  out  1  high while in DEAD state.

Behaviour:
- Reset (async, rst_n=0): synchroniser, edge register, gate counter, accumulator, dead counter cleared; state IDLE; count_out=0, count_valid=0, count_sat=0, overrun=0, dead_active=0.
- Synchroniser: SYNC_STAGES flops, reset 0. Edge = sync output 1 while previous sync output 0. Latency: pulse_in rising, setup met before edge k -> edge strobe during cycle k+SYNC_STAGES-1 -> accumulator updated at edge k+SYNC_STAGES. Edge detection runs in all states.
- FSM:
  - IDLE: entered when ena=0. Gate counter, accumulator and dead counter held at 0. Edges ignored. -> ARMED when ena=1.
  - ARMED: edge strobe -> accept hit (accumulator +1). If DEAD_CYCLES>0 -> DEAD and load dead counter with DEAD_CYCLES; otherwise stay ARMED.
  - DEAD: dead_active=1. Edges dropped. Counter decrements each cycle; -> ARMED on the cycle the counter reaches 1, so exactly DEAD_CYCLES blanked cycles.
  - Any state with ena=0 -> IDLE next edge.
- Gate counter runs 0..GATE_CYCLES-1 in ARMED and DEAD; dead time continues across window boundaries.
- Window close, when gate counter = GATE_CYCLES-1:
  - count_out <= accumulator + accepted-hit-this-cycle, saturated.
  - count_sat <= saturation flag of that window.
  - count_valid <= 1.
  - Accumulator, sat flag and gate counter cleared.
  - A hit accepted on the closing cycle belongs to the closing window.
- Saturation: accumulator stops at 2^CNT_W-1, and the window's sat flag is set. No wrap.
- Handshake: result held stable while count_valid=1 and count_ready=0.
  - count_valid=1 and count_ready=1 with no close -> count_valid=0 next cycle.
  - Close while count_valid=1 and count_ready=0 -> new result overwrites, count_valid stays 1, overrun set (sticky until reset).
  - Close together with count_ready=1 -> new result loaded, count_valid stays 1, no overrun.
- ena deassert mid-window: partial window discarded (no result produced). A pending result and its count_valid are kept, and the handshake still operates.
- ena reassert: new window starts from gate count 0.
- Minimum resolvable pulse spacing with DEAD_CYCLES=0: 2 cycles, since the line must return low to be seen again.

Test Plan:
(Bench uses GATE_CYCLES=100, DEAD_CYCLES=4, CNT_W=8, SYNC_STAGES=2, count_ready=1 unless stated.)
- Reset/idle: rst_n low then high with ena=0 and pulses toggling -> all outputs 0, count_valid never asserts.
- Basic count: ena=1, 10 one-cycle pulses spaced 10 cycles apart in window 1 -> count_valid pulses 1 cycle at window end with count_out=10, count_sat=0; next empty window -> count_out=0.
- Dead time: pulses 3 cycles apart for 30 pulses -> every other pulse dropped (spacing < 5), count_out=15. dead_active high 4 cycles after each accepted hit.
- Saturation: pulse_in toggling every cycle with DEAD_CYCLES=0 for 100 cycles -> ~50 hits, count_out=50. Rerun with CNT_W=5 -> count_out=31, count_sat=1.
- Backpressure: count_ready=0 across two window closes -> first result replaced by second, overrun=1, count_valid stays 1. Then raise count_ready for 1 cycle -> count_valid=0.
- Boundary/abort: pulse arriving so its hit is accepted on gate cycle 99 -> counted in that window. ena dropped at gate cycle 50 with 5 hits -> no result; ena re-raised -> next window counts from 0.
- Async reset mid-DEAD with count_valid=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/pulse_rate_counter.sv
// Purpose: synchronise an async pulse line, apply dead time, count hits per gate window.
// Latency: pulse_in rise -> hit counted SYNC_STAGES+1 edges later; window result 1 cycle after close.
// Backpressure: result held until count_ready; a close while unread overwrites and sets sticky overrun.
module pulse_rate_counter #(
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = 1000,
  parameter int DEAD_CYCLES = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             count_sat,
  output logic             overrun,
  output logic             dead_active
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int DEAD_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   edge_stb;

  logic [GATE_W-1:0] gate_q;
  logic [DEAD_W-1:0] dead_cnt_q;
  logic [CNT_W-1:0]  acc_q;
  logic              sat_q;

  logic              hit_acc;
  logic              dead_load;
  logic              running;
  logic              win_close;
  logic              acc_at_max;
  logic [CNT_W-1:0]  acc_next;
  logic              sat_next;

  // Metastability chain on the asynchronous pulse line, oldest sample in the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
    end
  end

  // Previous synchronised level, so a held-high line yields a single strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_prev_q <= 1'b0;
    end else begin
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_stb = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  // Window and dead logic only advance while enabled and out of IDLE.
  assign running   = ena && (state_q != ST_IDLE);
  assign win_close = running && (gate_q == GATE_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, hit acceptance and dead-time indication.
  always_comb begin
    state_d     = state_q;
    hit_acc     = 1'b0;
    dead_load   = 1'b0;
    dead_active = (state_q == ST_DEAD);
    if (!ena) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (edge_stb) begin
            hit_acc = 1'b1;
            if (DEAD_CYCLES > 0) begin
              state_d   = ST_DEAD;
              dead_load = 1'b1;
            end
          end
        end
        ST_DEAD: begin
          // Leaving when the counter shows 1 gives exactly DEAD_CYCLES blanked cycles.
          if (dead_cnt_q <= DEAD_ONE) begin
            state_d = ST_ARMED;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Dead-time counter: loaded on an accepted hit, counts down while blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt_q <= '0;
    end else if (!running) begin
      dead_cnt_q <= '0;
    end else if (dead_load) begin
      dead_cnt_q <= DEAD_LOAD;
    end else if ((state_q == ST_DEAD) && (dead_cnt_q != '0)) begin
      dead_cnt_q <= dead_cnt_q - DEAD_ONE;
    end
  end

  // Gate counter: 0..GATE_CYCLES-1, restarted by a close or by leaving the running states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
    end else if (!running || win_close) begin
      gate_q <= '0;
    end else begin
      gate_q <= gate_q + GATE_ONE;
    end
  end

  // Saturating accumulate; a hit arriving at the ceiling marks the window saturated.
  assign acc_at_max = (acc_q == CNT_MAX);
  assign acc_next   = (hit_acc && !acc_at_max) ? (acc_q + CNT_ONE) : acc_q;
  assign sat_next   = sat_q | (hit_acc & acc_at_max);

  // Hit accumulator; cleared at close (the closing hit is already in acc_next) or on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (!running || win_close) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_next;
      sat_q <= sat_next;
    end
  end

  // Result register with valid/ready; a close always loads, consumption clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out   <= '0;
      count_sat   <= 1'b0;
      count_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (win_close) begin
      count_out   <= acc_next;
      count_sat   <= sat_next;
      count_valid <= 1'b1;
      if (count_valid && !count_ready) begin
        overrun <= 1'b1;
      end
    end else if (count_valid && count_ready) begin
      count_valid <= 1'b0;
    end
  end

  // An unconsumed result stays put unless a new window closes over it.
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (count_valid && !count_ready && !win_close) |=>
      (count_valid && $stable(count_out) && $stable(count_sat)));

  // Blanking always has cycles left to run while in DEAD.
  a_dead_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_DEAD) |-> (dead_cnt_q != '0));

  // IDLE holds the window machinery cleared.
  a_idle_clear: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_IDLE) |-> ((gate_q == '0) && (acc_q == '0) && !sat_q));

endmodule
